pixel_contrast_pipe: RTL
========================

// Module: pixel_contrast_pipe
// PURPOSE
//  Parametrised, pipelined per-pixel colour filter for the VGA pixel path (camera/ROM -> filter -> VGA).
//  Provides four switch-selected modes: bypass, invert, contrast gain and threshold, plus per-channel enables.
//  Uses a valid/ready stream with start-of-frame marking; mode changes take effect only at a frame boundary.
// PARAMETERS
//  CW          4              channel width in bits (R,G,B each)
//  GAIN_NUM    3              contrast gain numerator (unsigned, 1..15)
//  GAIN_SHIFT  1              contrast gain = GAIN_NUM / 2^GAIN_SHIFT
//  THRESH      2**(CW-1)      threshold-mode cut level
// PORTS
//  clk        in   1    pixel clock
//  rst_n      in   1    asynchronous active-low reset
//  mode_sel   in   2    00 bypass, 01 invert, 10 contrast, 11 threshold
//  ch_en      in   3    {r,g,b} channel enables; disabled channel outputs 0
//  in_valid   in   1    input pixel valid
//  in_ready   out  1    block can accept a pixel this cycle
//  in_sof     in   1    first pixel of frame (qualified by in_valid)
//  in_r/g/b   in   CW   input channels
//  out_valid  out  1    output pixel valid
//  out_ready  in   1    downstream accepts
//  out_sof    out  1    sof delayed in lockstep with the pixel
//  out_r/g/b  out  CW   filtered channels
// BEHAVIOUR
//  Reset: out_valid=0, out_sof=0, out_r/g/b=0, all stage valids=0; cfg_mode=00, cfg_en=3'b111.
//  Pipeline: 3 stages. S1 captures pixel+cfg, S2 arithmetic, S3 clamp+channel mask+output regs.
//  Advance: adv = !out_valid | out_ready; all stages shift together on adv; in_ready = adv.
//  Accept = in_valid & in_ready. Latency = 3 adv cycles. Bubbles are not collapsed. No loss or reorder.
//  Config: mode_sel/ch_en sampled into cfg_* only on an accepted beat with in_sof=1; that pixel and the
//   rest of its frame use the new cfg. Changes mid-frame are ignored until the next sof.
//  Arithmetic per channel x (MAX = 2^CW-1, MID = 2^(CW-1)):
//   bypass:    y = x
//   invert:    y = MAX - x
//   contrast:  y = clamp(((x-MID)*GAIN_NUM >>> GAIN_SHIFT) + MID, 0, MAX); signed, width CW+6, arithmetic shift
//   threshold: y = (x >= THRESH) ? MAX : 0
//  Channel mask: y = cfg_en[ch] ? y : 0.
//  Reset mid-stream: all in-flight pixels are discarded; the first frame after reset uses reset cfg until a sof.
// CONFIGURATION
//  `AUTO_STRETCH_EN defined: per-channel min/max tracking over every accepted pixel of a frame.
//   On each accepted sof, the tracked min/max are transferred into lvl_min[ch] and sh[ch], then the trackers restart.
//   sh = largest s in 0..CW-1 with (max-min)<<s <= MAX; if max==min then lvl_min=0 and sh=0.
//   Contrast mode then uses y = x<lvl_min ? 0 : clamp((x-lvl_min)<<sh, 0, MAX) instead of the gain formula.
//   Reset values: lvl_min=0, sh=0 (identity).
//  `AUTO_STRETCH_EN undefined: no trackers; contrast mode uses the fixed GAIN_NUM/GAIN_SHIFT formula.
// STRUCTURE
//  Package pixel_filter_pkg: mode encodings (MODE_BYPASS..MODE_THRESH), MAX/MID constants as functions of CW,
//   and a clamp function.
//  Sub-module pixel_channel_op: one channel's S2/S3 arithmetic and mask, instantiated 3x.
//  Top level holds the cfg registers, the valid/sof pipeline, the adv logic and the optional trackers.
// TESTING (CW=4, defaults)
//  1 reset: assert rst_n=0 mid-stream -> out_valid=0, out_r/g/b=0 immediately; in_ready=1 after release.
//  2 bypass: mode 00, ch_en 111, sof pixel (3,9,15), out_ready=1 -> out (3,9,15) with out_sof=1, 3 cycles later.
//  3 invert: mode 01, (3,9,15) -> (12,6,0); with ch_en=101 -> (12,0,0).
//  4 contrast: mode 10, channel x=2,12,15 -> y=0,14,15 (clamped low, mid, clamped high).
//  5 backpressure: stream 6 pixels, out_ready=0 for 5 cycles -> in_ready=0 while stalled, all 6 delivered in order;
//    mode_sel toggled mid-frame -> output unchanged until the next sof.
//  6 AUTO_STRETCH_EN: frame1 red in [4,7] -> sh=2; frame2 red 5,3,9 -> 4,0,15.

Source files
------------

// File: rtl/pixel_filter_pkg.sv
// Shared mode encodings, channel-range helpers and clamp for the pixel filter.
package pixel_filter_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'b00,
    MODE_INVERT   = 2'b01,
    MODE_CONTRAST = 2'b10,
    MODE_THRESH   = 2'b11
  } mode_e;

  function automatic int max_val(input int cw);
    return (1 << cw) - 1;
  endfunction

  function automatic int mid_val(input int cw);
    return 1 << (cw - 1);
  endfunction

  function automatic int sh_width(input int cw);
    return (cw > 1) ? $clog2(cw) : 1;
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Largest s in 0..cw-1 that keeps span<<s inside the channel range.
  function automatic int stretch_shift(input int span, input int cw);
    int s_best = 0;
    for (int s = 0; s < cw; s++) begin
      if ((span << s) <= max_val(cw)) s_best = s;
    end
    return s_best;
  endfunction

endpackage

// File: rtl/pixel_channel_op.sv
// One colour channel's arithmetic stage (S2) and clamp/mask output stage (S3).
// AUTO_STRETCH_EN selects the level-stretch contrast path instead of fixed gain.
module pixel_channel_op
  import pixel_filter_pkg::*;
#(
  parameter int unsigned CW         = 4,
  parameter int unsigned GAIN_NUM   = 3,
  parameter int unsigned GAIN_SHIFT = 1,
  parameter int unsigned THRESH     = 2 ** (CW - 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  mode_e         mode,
  input  logic          en,
  input  logic [CW-1:0] x,
`ifdef AUTO_STRETCH_EN
  input  logic [CW-1:0] lvl_min,
  input  logic [sh_width(CW)-1:0] sh,
`endif
  output logic [CW-1:0] y
);

  localparam int unsigned AW = CW + 6;
  localparam logic signed [AW-1:0] MAX_S = AW'(max_val(CW));
  localparam logic [CW-1:0] THR = CW'(THRESH);
`ifndef AUTO_STRETCH_EN
  localparam logic signed [AW-1:0] MID_S  = AW'(mid_val(CW));
  localparam logic signed [AW-1:0] GAIN_S = AW'(GAIN_NUM);
`endif

  logic signed [AW-1:0] xs;
  logic signed [AW-1:0] arith;
  logic signed [AW-1:0] s2_val;
  logic                 s2_en;

  // Unclamped per-mode result, kept signed so contrast can go below zero.
  always_comb begin
    xs    = AW'(x);
    arith = xs;
    case (mode)
      MODE_BYPASS:   arith = xs;
      MODE_INVERT:   arith = MAX_S - xs;
`ifdef AUTO_STRETCH_EN
      MODE_CONTRAST: arith = (x < lvl_min) ? '0 : (AW'(x - lvl_min) << sh);
`else
      MODE_CONTRAST: arith = (((xs - MID_S) * GAIN_S) >>> GAIN_SHIFT) + MID_S;
`endif
      MODE_THRESH:   arith = (x >= THR) ? MAX_S : '0;
      default:       arith = xs;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_val <= '0;
      s2_en  <= 1'b0;
      y      <= '0;
    end else if (adv) begin
      s2_val <= arith;
      s2_en  <= en;
      y      <= s2_en ? CW'(clamp(int'(s2_val), 0, max_val(CW))) : '0;
    end
  end

endmodule

// File: rtl/pixel_contrast_pipe.sv
// Three-stage valid/ready per-pixel colour filter with frame-aligned config.
// Optional per-frame auto level stretch under `AUTO_STRETCH_EN.
module pixel_contrast_pipe
  import pixel_filter_pkg::*;
#(
  parameter int unsigned CW         = 4,
  parameter int unsigned GAIN_NUM   = 3,
  parameter int unsigned GAIN_SHIFT = 1,
  parameter int unsigned THRESH     = 2 ** (CW - 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode_sel,
  input  logic [2:0]    ch_en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [CW-1:0] in_r,
  input  logic [CW-1:0] in_g,
  input  logic [CW-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic [CW-1:0] out_r,
  output logic [CW-1:0] out_g,
  output logic [CW-1:0] out_b
);

  logic          adv;
  logic          accept;
  logic          sof_acc;
  mode_e         cfg_mode;
  mode_e         eff_mode;
  mode_e         s1_mode;
  logic [2:0]    cfg_en;
  logic [2:0]    eff_en;
  logic [2:0]    s1_en;
  logic          s1_valid;
  logic          s1_sof;
  logic          s2_valid;
  logic          s2_sof;
  logic [CW-1:0] in_pix  [3];
  logic [CW-1:0] s1_pix  [3];
  logic [CW-1:0] out_pix [3];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign sof_acc  = accept && in_sof;

  // A sof beat already uses the settings it carries.
  assign eff_mode = sof_acc ? mode_e'(mode_sel) : cfg_mode;
  assign eff_en   = sof_acc ? ch_en : cfg_en;

  assign in_pix[0] = in_r;
  assign in_pix[1] = in_g;
  assign in_pix[2] = in_b;
  assign out_r     = out_pix[0];
  assign out_g     = out_pix[1];
  assign out_b     = out_pix[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_mode <= MODE_BYPASS;
      cfg_en   <= 3'b111;
    end else if (sof_acc) begin
      cfg_mode <= mode_e'(mode_sel);
      cfg_en   <= ch_en;
    end
  end

  // Valid/sof pipeline and S1 capture; all stages move together on adv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s2_valid  <= 1'b0;
      s2_sof    <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      s1_mode   <= MODE_BYPASS;
      s1_en     <= 3'b111;
      for (int i = 0; i < 3; i++) s1_pix[i] <= '0;
    end else if (adv) begin
      s1_valid  <= accept;
      s1_sof    <= sof_acc;
      s2_valid  <= s1_valid;
      s2_sof    <= s1_sof;
      out_valid <= s2_valid;
      out_sof   <= s2_sof;
      if (accept) begin
        s1_mode <= eff_mode;
        s1_en   <= eff_en;
        for (int i = 0; i < 3; i++) s1_pix[i] <= in_pix[i];
      end
    end
  end

`ifdef AUTO_STRETCH_EN
  localparam int unsigned SW = sh_width(CW);

  logic [CW-1:0] trk_min [3];
  logic [CW-1:0] trk_max [3];
  logic [CW-1:0] lvl_min [3];
  logic [CW-1:0] new_lvl [3];
  logic [CW-1:0] s1_lvl  [3];
  logic [SW-1:0] lvl_sh  [3];
  logic [SW-1:0] new_sh  [3];
  logic [SW-1:0] s1_sh   [3];

  // Empty or flat frame falls back to identity.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      new_lvl[i] = '0;
      new_sh[i]  = '0;
      if (trk_max[i] > trk_min[i]) begin
        new_lvl[i] = trk_min[i];
        new_sh[i]  = SW'(stretch_shift(int'(trk_max[i] - trk_min[i]), CW));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        trk_min[i] <= CW'(max_val(CW));
        trk_max[i] <= '0;
        lvl_min[i] <= '0;
        lvl_sh[i]  <= '0;
        s1_lvl[i]  <= '0;
        s1_sh[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sof_acc) begin
          lvl_min[i] <= new_lvl[i];
          lvl_sh[i]  <= new_sh[i];
          trk_min[i] <= in_pix[i];
          trk_max[i] <= in_pix[i];
        end else if (accept) begin
          if (in_pix[i] < trk_min[i]) trk_min[i] <= in_pix[i];
          if (in_pix[i] > trk_max[i]) trk_max[i] <= in_pix[i];
        end
        if (accept) begin
          s1_lvl[i] <= sof_acc ? new_lvl[i] : lvl_min[i];
          s1_sh[i]  <= sof_acc ? new_sh[i] : lvl_sh[i];
        end
      end
    end
  end
`endif

  for (genvar i = 0; i < 3; i++) begin : g_ch
    pixel_channel_op #(
      .CW         (CW),
      .GAIN_NUM   (GAIN_NUM),
      .GAIN_SHIFT (GAIN_SHIFT),
      .THRESH     (THRESH)
    ) u_op (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (adv),
      .mode    (s1_mode),
      .en      (s1_en[2-i]),
      .x       (s1_pix[i]),
`ifdef AUTO_STRETCH_EN
      .lvl_min (s1_lvl[i]),
      .sh      (s1_sh[i]),
`endif
      .y       (out_pix[i])
    );
  end

endmodule
